// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the ALU operation sequencer.
// Contains the ALUOp encodings, the opcode/funct field values and the
// sequencer FSM state type.
package alu_seq_pkg;

    // ALUOp codes understood by the ALU. 100/110/111 are never produced.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Instruction opcode field values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // R-type funct field values
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: purely combinational mapping of opcode/funct to ALUOp,
// plus a beq marker and an illegal-instruction flag.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       is_beq,
    output logic       illegal
);

    // Decode table; anything not listed is flagged illegal and keeps ALU_ADD
    always_comb begin
        alu_op  = ALU_ADD;
        is_beq  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
            OP_BEQ: begin
                alu_op = ALU_SUB;
                is_beq = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one decoded command at a time, drives the
// external combinational ALU for one cycle and returns a registered response.
// Optional feature macro: ALU_SEQ_PERF_EN adds the op_count port, a count of
// completed legal responses.
//
// Handshakes: both cmd and rsp are strict valid/ready. A beat transfers on a
// rising edge where valid and ready are both high. cmd_ready is high only in
// IDLE; rsp_valid is high only in RESP and every rsp_* output is held stable
// until the transfer, so a stalled consumer sees no change.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [5:0]   cmd_opcode,
    input  logic [5:0]   cmd_funct,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_taken,
    output logic         rsp_illegal
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [31:0]  op_count
`endif
);

    seq_state_t   state_q, state_d;
    logic [W-1:0] cap_a, cap_b;
    logic [2:0]   cap_op;
    logic         cap_beq;
    logic [2:0]   dec_op;
    logic         dec_beq, dec_illegal;
    logic         cmd_fire, rsp_fire;

    alu_op_decode u_decode (
        .opcode  (cmd_opcode),
        .funct   (cmd_funct),
        .alu_op  (dec_op),
        .is_beq  (dec_beq),
        .illegal (dec_illegal)
    );

    assign cmd_fire = cmd_valid & cmd_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

    // ALU operands always show the last legal capture; the op code is only
    // non-add while actually executing.
    assign alu_a  = cap_a;
    assign alu_b  = cap_b;
    assign alu_op = (state_q == ST_EXEC) ? cap_op : ALU_ADD;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and handshake outputs; illegal commands skip EXEC
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = dec_illegal ? ST_RESP : ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture operands and decoded op of legal commands only, so an illegal
    // command leaves the ALU inputs untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_a   <= '0;
            cap_b   <= '0;
            cap_op  <= ALU_ADD;
            cap_beq <= 1'b0;
        end else if (cmd_fire && !dec_illegal) begin
            cap_a   <= cmd_a;
            cap_b   <= cmd_b;
            cap_op  <= dec_op;
            cap_beq <= dec_beq;
        end
    end

    // Response registers: loaded at accept for illegal commands, at the end
    // of EXEC for legal ones, otherwise held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_taken   <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (cmd_fire && dec_illegal) begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_taken   <= 1'b0;
            rsp_illegal <= 1'b1;
        end else if (state_q == ST_EXEC) begin
            rsp_result  <= alu_result;
            rsp_zero    <= alu_zero;
            rsp_taken   <= cap_beq & alu_zero;
            rsp_illegal <= 1'b0;
        end
    end

`ifdef ALU_SEQ_PERF_EN
    // Count legal responses as they are handed off; wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      op_count <= '0;
        else if (rsp_fire && !rsp_illegal) op_count <= op_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench for alu_op_sequencer with a small
// behavioural ALU attached. Inputs change and outputs are sampled on the
// falling edge. Build with ALU_SEQ_PERF_EN defined to also cover op_count.
module tb_alu_op_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [5:0]   cmd_opcode;
    logic [5:0]   cmd_funct;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_taken;
    logic         rsp_illegal;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0]  op_count;
`endif

    int tests_run;
    int tests_failed;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    alu_op_sequencer #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_funct   (cmd_funct),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_taken   (rsp_taken),
        .rsp_illegal (rsp_illegal)
`ifdef ALU_SEQ_PERF_EN
        ,
        .op_count    (op_count)
`endif
    );

    // ---------------- behavioural ALU ----------------
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == '0);
    end

    // ---------------- driver tasks ----------------
    // Present a command at a falling edge while IDLE; returns at the falling
    // edge right after the accepting rising edge.
    task automatic drive_cmd(input logic [5:0] op, input logic [5:0] fn,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        cmd_opcode = op;
        cmd_funct  = fn;
        cmd_a      = a;
        cmd_b      = b;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Issue a command and wait (bounded) for rsp_valid. lat = number of
    // rising edges from command presentation to rsp_valid visible.
    task automatic exec_cmd(input logic [5:0] op, input logic [5:0] fn,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            output int lat);
        drive_cmd(op, fn, a, b);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Let the pending response transfer (rsp_ready is high)
    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_opcode = '0; cmd_funct = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hs got ready=%b valid=%b exp ready=1 valid=0", cmd_ready, rsp_valid);
        end
        tests_run++;
        if (rsp_result !== '0 || rsp_zero !== 1'b0 || rsp_taken !== 1'b0 || rsp_illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rsp got res=%0h z=%b t=%b i=%b exp all 0", rsp_result, rsp_zero, rsp_taken, rsp_illegal);
        end
        tests_run++;
        if (alu_a !== '0 || alu_b !== '0 || alu_op !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_alu got a=%0h b=%0h op=%b exp 0 0 000", alu_a, alu_b, alu_op);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        drive_cmd(6'b000000, 6'b100000, 32'd5, 32'd7);
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || alu_op !== 3'b000) begin
            tests_failed++;
            $display("FAIL add_exec got valid=%b ready=%b op=%b exp 0 0 000", rsp_valid, cmd_ready, alu_op);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_latency got rsp_valid=%b exp 1 two edges after presenting", rsp_valid);
        end
        tests_run++;
        if (rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_illegal !== 1'b0 || rsp_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_rsp got res=%0d z=%b i=%b t=%b exp 12 0 0 0", rsp_result, rsp_zero, rsp_illegal, rsp_taken);
        end
        release_rsp();
        tests_run++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_drain got ready=%b valid=%b exp 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_beq();
        drive_cmd(6'b000100, 6'b000000, 32'h1234, 32'h1234);
        tests_run++;
        if (alu_op !== 3'b001) begin
            tests_failed++;
            $display("FAIL beq_aluop got %b exp 001", alu_op);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_result !== '0 || rsp_zero !== 1'b1 || rsp_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL beq_taken got v=%b res=%0h z=%b t=%b exp 1 0 1 1", rsp_valid, rsp_result, rsp_zero, rsp_taken);
        end
        release_rsp();
        drive_cmd(6'b000100, 6'b000000, 32'h1234, 32'h1235);
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'hFFFF_FFFF || rsp_zero !== 1'b0 || rsp_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL beq_not_taken got v=%b res=%0h z=%b t=%b exp 1 ffffffff 0 0", rsp_valid, rsp_result, rsp_zero, rsp_taken);
        end
        release_rsp();
    endtask

    task automatic test_ops();
        // opcode, funct, a, b, expected result, expected zero
        logic [5:0]   t_op [6] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b101011};
        logic [5:0]   t_fn [6] = '{6'b101010, 6'b100010, 6'b100100, 6'b100101, 6'b000000, 6'b000000};
        logic [W-1:0] t_a  [6] = '{32'd3, 32'd9, 32'hF0F0, 32'hF000, 32'd10, 32'd4};
        logic [W-1:0] t_b  [6] = '{32'd9, 32'd9, 32'h0FF0, 32'h000F, 32'hFFFF_FFFD, 32'd8};
        logic [W-1:0] t_r  [6] = '{32'd1, 32'd0, 32'h00F0, 32'hF00F, 32'd7, 32'd12};
        logic         t_z  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        // Reordered so that OR is the last legal op (its operands are reused)
        int order [6] = '{0, 1, 2, 4, 5, 3};
        int lat;
        for (int k = 0; k < 6; k++) begin
            int i = order[k];
            exec_cmd(t_op[i], t_fn[i], t_a[i], t_b[i], lat);
            tests_run++;
            if (lat !== 2 || rsp_result !== t_r[i] || rsp_zero !== t_z[i] || rsp_illegal !== 1'b0 || rsp_taken !== 1'b0) begin
                tests_failed++;
                $display("FAIL op_%0d got lat=%0d res=%0h z=%b i=%b t=%b exp lat=2 res=%0h z=%b i=0 t=0",
                         i, lat, rsp_result, rsp_zero, rsp_illegal, rsp_taken, t_r[i], t_z[i]);
            end
            release_rsp();
        end
    endtask

    task automatic test_illegal();
        int lat;
        // Last legal capture was OR 0xF000 | 0x000F
        exec_cmd(6'b111111, 6'b000000, 32'hDEAD, 32'hBEEF, lat);
        tests_run++;
        if (lat !== 1 || rsp_illegal !== 1'b1 || rsp_result !== '0 || rsp_zero !== 1'b0 || rsp_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_op got lat=%0d i=%b res=%0h z=%b t=%b exp lat=1 i=1 res=0 z=0 t=0",
                     lat, rsp_illegal, rsp_result, rsp_zero, rsp_taken);
        end
        tests_run++;
        if (alu_a !== 32'hF000 || alu_b !== 32'h000F || alu_op !== 3'b000 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_alu got a=%0h b=%0h op=%b ready=%b exp f000 f 000 0", alu_a, alu_b, alu_op, cmd_ready);
        end
        release_rsp();
        exec_cmd(6'b000000, 6'b000000, 32'd1, 32'd2, lat);
        tests_run++;
        if (lat !== 1 || rsp_illegal !== 1'b1 || rsp_result !== '0) begin
            tests_failed++;
            $display("FAIL illegal_funct got lat=%0d i=%b res=%0h exp lat=1 i=1 res=0", lat, rsp_illegal, rsp_result);
        end
        release_rsp();
    endtask

    task automatic test_stall();
        int lat;
        int bad;
        rsp_ready = 1'b0;
        exec_cmd(6'b000000, 6'b100000, 32'd100, 32'd23, lat);
        // Offer a different command while the response is stalled
        cmd_opcode = 6'b001000; cmd_funct = '0; cmd_a = 32'd1; cmd_b = 32'd1;
        cmd_valid  = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd123 || rsp_illegal !== 1'b0 || cmd_ready !== 1'b0)
                bad++;
        end
        tests_run++;
        if (lat !== 2 || bad !== 0) begin
            tests_failed++;
            $display("FAIL stall_hold got lat=%0d bad_cycles=%0d res=%0d exp lat=2 bad_cycles=0 res=123", lat, bad, rsp_result);
        end
        cmd_valid = 1'b0;
        release_rsp();
        repeat (3) @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_no_accept got valid=%b ready=%b exp 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        drive_cmd(6'b000000, 6'b100010, 32'd50, 32'd8);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_op !== 3'b000 || alu_a !== '0 || alu_b !== '0 || rsp_result !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid got ready=%b valid=%b op=%b a=%0h b=%0h res=%0h exp 1 0 000 0 0 0",
                     cmd_ready, rsp_valid, alu_op, alu_a, alu_b, rsp_result);
        end
`ifdef ALU_SEQ_PERF_EN
        tests_run++;
        if (op_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_count got %0d exp 0", op_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exec_cmd(6'b000000, 6'b100000, 32'd1, 32'd1, lat);
        tests_run++;
        if (lat !== 2 || rsp_result !== 32'd2 || rsp_illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_add got lat=%0d res=%0d i=%b exp lat=2 res=2 i=0", lat, rsp_result, rsp_illegal);
        end
        release_rsp();
    endtask

`ifdef ALU_SEQ_PERF_EN
    task automatic test_perf();
        int lat;
        // One legal op already completed since the last reset
        exec_cmd(6'b100011, 6'b000000, 32'd4, 32'd4, lat);
        release_rsp();
        exec_cmd(6'b111111, 6'b000000, 32'd0, 32'd0, lat);
        release_rsp();
        exec_cmd(6'b000000, 6'b100100, 32'd3, 32'd1, lat);
        tests_run++;
        if (op_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL perf_stalled got %0d exp 2", op_count);
        end
        release_rsp();
        tests_run++;
        if (op_count !== 32'd3) begin
            tests_failed++;
            $display("FAIL perf_count got %0d exp 3", op_count);
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add();
        test_beq();
        test_ops();
        test_illegal();
        test_stall();
        test_reset_mid();
`ifdef ALU_SEQ_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
